// File: rtl/psum_requant_if.sv
// Streaming port bundle for psum_requant: partial-sum input channel and requantized pixel output.
// DATA_BIT (shared with mac) sets the pixel width; it defaults to 16 when not defined globally.
`ifndef DATA_BIT
`define DATA_BIT 16
`endif

// Both channels are valid/ready: a beat transfers on a rising edge where valid && ready.
// The source keeps valid and its payload stable until that edge; ready may depend on state only.
interface psum_requant_if #(
  parameter int DW = `DATA_BIT
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic signed [2*DW+1:0] in_psum;
  logic                   in_last;
  logic signed [DW-1:0]   bias;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   out_data;

  modport slave (
    input  in_valid, in_psum, in_last, bias, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_psum, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/psum_requant.sv
// Accumulates signed MAC partial sums per pixel, adds bias, rounds/shifts/saturates to DATA_BIT.
// Optional build macro PSUM_RELU_EN zeroes negative results after clamping.
`ifndef DATA_BIT
`define DATA_BIT 16
`endif

module psum_requant #(
  parameter int SHIFT    = 8,
  parameter int MAX_PSUM = 16
) (
  input  logic            clk,
  input  logic            rst,
  psum_requant_if.slave   bus,
  output logic            sat_flag,
  output logic            err_flag,
  output logic            state_dbg
);

  localparam int DW = `DATA_BIT;
  localparam int PW = 2*DW + 2;
  localparam int AW = 2*DW + 6;
  localparam int CW = $clog2(MAX_PSUM + 1);

  // Requantization runs one bit wider than the accumulator so the rounding add cannot wrap.
  localparam logic signed [AW:0] HALF = (AW+1)'(1) << (SHIFT - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (DW - 1)) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state, state_nx;

  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] pend_acc;
  logic                 pend_valid;
  logic signed [DW-1:0] hold_data;
  logic                 out_valid_q;
  logic signed [DW-1:0] out_data_q;

  logic                 in_ready_c;
  logic                 accept;
  logic                 closing;
  logic                 out_free;
  logic                 load_pend;
  logic                 load_hold;
  logic                 to_hold;

  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] psum_ext;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] acc_sum;

  logic signed [AW:0]   rnd;
  logic signed [AW:0]   shifted;
  logic signed [DW-1:0] rq_data;
  logic                 rq_sat;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign state_dbg     = (state == S_HOLD);

  assign accept   = bus.in_valid && in_ready_c;
  assign out_free = !out_valid_q || bus.out_ready;
  assign closing  = bus.in_last || (cnt == CW'(MAX_PSUM - 1));

  // The bias enters pre-scaled by SHIFT so the final shift treats it as a whole pixel offset.
  always_comb begin
    bias_ext = {{(AW-DW){bus.bias[DW-1]}}, bus.bias};
    psum_ext = {{(AW-PW){bus.in_psum[PW-1]}}, bus.in_psum};
    acc_base = (cnt == '0) ? (bias_ext <<< SHIFT) : acc;
    acc_sum  = acc_base + psum_ext;
  end

  // Round half up, floor-shift, clamp; ReLU (when built in) acts on the clamped value.
  always_comb begin
    rnd     = $signed({pend_acc[AW-1], pend_acc}) + HALF;
    shifted = rnd >>> SHIFT;
    rq_sat  = 1'b0;
    rq_data = shifted[DW-1:0];
    if (shifted > MAXV) begin
      rq_data = MAXV[DW-1:0];
      rq_sat  = 1'b1;
    end else if (shifted < MINV) begin
      rq_data = MINV[DW-1:0];
      rq_sat  = 1'b1;
    end
`ifdef PSUM_RELU_EN
    if (rq_data[DW-1]) begin
      rq_data = '0;
    end
`else
    rq_data = rq_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_ACC;
    end else begin
      state <= state_nx;
    end
  end

  // A finished pixel waits in pend_acc; if the output is busy it is parked in hold_data.
  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    load_pend  = 1'b0;
    load_hold  = 1'b0;
    to_hold    = 1'b0;
    case (state)
      S_ACC: begin
        in_ready_c = rst;
        if (pend_valid) begin
          if (out_free) begin
            load_pend = 1'b1;
          end else begin
            to_hold  = 1'b1;
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_free) begin
          load_hold = 1'b1;
          state_nx  = S_ACC;
        end
      end
      default: state_nx = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        acc <= '0;
        cnt <= '0;
        if (!bus.in_last) begin
          err_flag <= 1'b1;
        end
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_acc   <= '0;
      pend_valid <= 1'b0;
      hold_data  <= '0;
      sat_flag   <= 1'b0;
    end else begin
      if (accept && closing) begin
        pend_acc   <= acc_sum;
        pend_valid <= 1'b1;
      end else if (load_pend || to_hold) begin
        pend_valid <= 1'b0;
      end
      if (to_hold) begin
        hold_data <= rq_data;
      end
      if ((load_pend || to_hold) && rq_sat) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // A reload in the handshake cycle keeps out_valid high, giving back-to-back pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load_pend) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rq_data;
    end else if (load_hold) begin
      out_valid_q <= 1'b1;
      out_data_q  <= hold_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: directed scenarios plus randomized pixels against an arithmetic model.
`ifndef DATA_BIT
`define DATA_BIT 16
`endif

module tb_psum_requant;
  localparam int DW       = `DATA_BIT;
  localparam int SHIFT    = 8;
  localparam int MAX_PSUM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sat_flag, err_flag, state_dbg;

  psum_requant_if #(.DW(DW)) bus ();

  psum_requant #(.SHIFT(SHIFT), .MAX_PSUM(MAX_PSUM)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sat_flag (sat_flag),
    .err_flag (err_flag),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rnd_bp = 1'b0;
  logic signed [DW-1:0] exp_q[$];
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     exp_sat = 1'b0;
  bit     exp_err = 1'b0;
  logic   prev_stall = 1'b0;
  logic signed [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pixel value straight from the arithmetic definition: floor((acc + 2^(S-1)) / 2^S), clamped.
  function automatic logic signed [DW-1:0] model_pixel(input longint acc, output bit sat);
    longint d, r, q, hi, lo;
    d  = longint'(1) << SHIFT;
    r  = acc + d / 2;
    q  = r / d;
    if (r < 0 && (r % d) != 0) q = q - 1;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
`ifdef PSUM_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_psum(input longint p, input bit last, input longint b);
    int waited;
    bit s;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_psum  = p[2*DW+1:0];
    bus.in_last  = last;
    bus.bias     = b[DW-1:0];
    while (!bus.in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (m_cnt == 0) m_acc = b * (longint'(1) << SHIFT);
    m_acc = m_acc + p;
    m_cnt++;
    if (last || m_cnt == MAX_PSUM) begin
      exp_q.push_back(model_pixel(m_acc, s));
      if (s) exp_sat = 1'b1;
      if (!last) exp_err = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && waited < 300) begin
      tick();
      waited++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard: every output handshake pops one expected pixel; stalled outputs must not change.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", bus.out_valid, 0);
        else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint p, b;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("in_ready_after_rst", bus.in_ready, 1);

    // basic accumulate: (2*256 + 6000 + 128) >> 8 = 25, one cycle after the last psum
    drive_psum(1000, 1'b0, 2);
    drive_psum(2000, 1'b0, 2);
    drive_psum(3000, 1'b1, 2);
    chk("basic_latency", bus.out_valid, 0);
    tick();
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_data", bus.out_data, 25);
    tick();
    chk("basic_sat", sat_flag, 0);
    chk("basic_err", err_flag, 0);

    // negative rounding
    drive_psum(-5000, 1'b1, 0);
    tick();
`ifdef PSUM_RELU_EN
    chk("neg_data", bus.out_data, 0);
`else
    chk("neg_data", bus.out_data, -20);
`endif
    chk("neg_sat", sat_flag, 0);

    // saturation at both rails
    drive_psum(longint'(1) << 30, 1'b1, 0);
    tick();
    chk("sat_pos_data", bus.out_data, 32767);
    chk("sat_pos_flag", sat_flag, 1);
    drive_psum(-(longint'(1) << 30), 1'b1, 0);
    tick();
`ifdef PSUM_RELU_EN
    chk("sat_neg_data", bus.out_data, 0);
`else
    chk("sat_neg_data", bus.out_data, -32768);
`endif
    drain();

    // backpressure: second pixel parks in HOLD and stalls the input
    bus.out_ready = 1'b0;
    drive_psum(256, 1'b1, 0);
    drive_psum(256, 1'b1, 0);
    tick();
    chk("bp_state_hold", state_dbg, 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 1);
    tick();
    tick();
    tick();
    chk("bp_in_ready_still", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second_valid", bus.out_valid, 1);
    chk("bp_second_data", bus.out_data, 1);
    chk("bp_in_ready_back", bus.in_ready, 1);
    chk("bp_state_acc", state_dbg, 0);
    tick();
    chk("bp_drained", bus.out_valid, 0);

    // back-to-back single-psum pixels with no bubble
    for (int i = 0; i < 4; i++) drive_psum(256 * (i + 1), 1'b1, 0);
    tick();
    chk("b2b_last", bus.out_data, 4);
    drain();

    // forced flush after MAX_PSUM partial sums without in_last
    for (int i = 0; i < MAX_PSUM; i++) drive_psum(256, 1'b0, 0);
    tick();
    chk("flush_data", bus.out_data, 16);
    chk("flush_err", err_flag, 1);
    drain();

    // reset mid-pixel discards the partial accumulation and all flags
    drive_psum(100, 1'b0, 0);
    drive_psum(200, 1'b0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_err", err_flag, 0);
    chk("mid_rst_state", state_dbg, 0);
    rst = 1'b1;
    m_cnt = 0;
    m_acc = 0;
    exp_q.delete();
    exp_sat = 1'b0;
    exp_err = 1'b0;
    tick();
    drive_psum(512, 1'b1, 0);
    tick();
    chk("post_rst_data", bus.out_data, 2);
    tick();
    chk("post_rst_sat", sat_flag, 0);
    chk("post_rst_err", err_flag, 0);

    // randomized pixels, bias changing every beat, random output backpressure
    rnd_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, MAX_PSUM + 2);
      for (int i = 0; i < n; i++) begin
        p = longint'($signed($urandom)) >>> $urandom_range(6, 20);
        b = longint'($signed(16'($urandom)));
        drive_psum(p, (i == n - 1), b);
      end
    end
    rnd_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("rand_sat", sat_flag, exp_sat);
    chk("rand_err", err_flag, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_requant.md
# psum_requant

Downstream post-processing stage for the 3-tap `mac` array. It accumulates a variable number of signed MAC partial sums per output pixel; a 3x3 convolution uses three rows, one `mac` result per row. It then adds a per-pixel bias, rounds and right-shifts, saturates to `DATA_BIT`, and presents one output pixel on a valid/ready port toward the output feature-map buffer. The `mac` result is consumed directly; `DATA_BIT` is the global macro used by `mac`.

## Interface
- `SHIFT`, 8: requantization right-shift, legal range 1..`DATA_BIT`.
- `MAX_PSUM`, 16: partial sums per pixel before a forced flush, legal range 2..16.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  partial sum present.
- `in_ready`  out  1  stage accepts a partial sum.
- `in_psum`  in  `DATA_BIT*2+2`  signed partial sum from `mac.out`.
- `in_last`  in  1  final partial sum of current pixel.
- `bias`  in  `DATA_BIT`  signed per-pixel bias.
- `out_valid`  out  1  output pixel present.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_data`  out  `DATA_BIT`  signed requantized pixel.
- `sat_flag`  out  1  sticky: any output saturated.
- `err_flag`  out  1  sticky: forced flush occurred.

## Operation
- A partial sum is accepted when `in_valid && in_ready`.
- Accumulator: signed, `DATA_BIT*2+6` bits, so it never overflows for 16 partial sums.
- First accepted partial sum of a pixel (count 0):
  - acc = `in_psum` + (sign-extended `bias` <<< `SHIFT`).
  - `bias` is sampled only in this cycle.
- Subsequent partial sums: acc += `in_psum`.
- The pixel closes on an accepted partial sum with `in_last=1`, or on the `MAX_PSUM`-th accepted partial sum.
  - Closing without `in_last` sets `err_flag`; the pixel is still produced normally.
  - A single partial sum with `in_last=1` is a complete pixel.
- Requantize the final acc:
  - r = (acc + (1 <<< (`SHIFT`-1))) >>> `SHIFT`, arithmetic shift, i.e. floor division.
  - Clamp r to [-2^(`DATA_BIT`-1), 2^(`DATA_BIT`-1)-1]. Clamping sets `sat_flag`.
- States:
  - ACC: `in_ready=1`. When a pixel closes:
    - If the output register is free (`!out_valid || out_ready`), load the result into it next cycle and stay in ACC.
    - Otherwise, store the result in the hold register and go to HOLD.
  - HOLD: `in_ready=0`. When the output register frees, move the held result into it and return to ACC.
- Output register:
  - `out_data` must stay stable while `out_valid && !out_ready`.
  - `out_valid` clears on handshake unless a new result loads in the same cycle.
- `sat_flag` and `err_flag` clear only on reset.

## Timing
- Reset while `rst=0` at a clock edge, including mid-pixel or in HOLD:
  - `out_valid=0`, `out_data=0`, `sat_flag=0`, `err_flag=0`.
  - Accumulator and count cleared, state ACC, partial accumulation discarded.
- `in_ready` is forced 0 while `rst=0`.
- Latency: a closing partial sum accepted at edge N gives `out_valid=1` after edge N+1 when no backpressure is present.
- Throughput: one partial sum per cycle. Single-partial-sum pixels sustain one pixel per cycle with `out_ready` held high.
- Simultaneous output handshake and new closing result in the same cycle: the register reloads and `out_valid` stays 1, with no bubble.
- `in_psum`, `in_last` and `bias` are ignored when `in_valid=0`.

## Configuration
- `PSUM_RELU_EN` defined: after clamping, negative results are forced to 0. A ReLU-zeroed value does not set `sat_flag`; only clamping does.
- `PSUM_RELU_EN` undefined: signed clamped result passes through unchanged.

## Test plan
All scenarios use `DATA_BIT=16` and `SHIFT=8`.
- Basic accumulate:
  - Stimulus: psums 1000, 2000, 3000 (last), bias 2, `out_ready=1`.
  - Response: `out_data=25` one cycle after the last psum; flags 0.
- Negative rounding:
  - Stimulus: psum -5000 (last), bias 0.
  - Response without `PSUM_RELU_EN`: `out_data=-20`.
  - Response with `PSUM_RELU_EN`: `out_data=0`.
- Saturation:
  - Stimulus: psum 2^30 (last).
  - Response: `out_data=32767`, `sat_flag=1`.
  - Stimulus: psum -2^30 without ReLU.
  - Response: `out_data=-32768`.
- Backpressure:
  - Stimulus: `out_ready=0`, two pixels each of one psum 256 (last), bias 0.
  - Response: first pixel `out_data=1` holds steady; second pixel → HOLD, `in_ready=0`.
  - Stimulus: raise `out_ready`.
  - Response: values 1 then 1 in consecutive cycles; `in_ready` returns to 1.
- Forced flush:
  - Stimulus: 16 psums of 256 with `in_last=0`.
  - Response: `out_data=16`, `err_flag=1`.
- Reset mid-pixel:
  - Stimulus: two psums accepted, then `rst=0` for one cycle, then psum 512 (last).
  - Response: `out_data=2`; prior accumulation discarded; all outputs 0 during reset.
